pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Generic, parametrised inter-stage pipeline register for the in-order core, used between any two adjacent stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries one flat payload vector under a valid/ready handshake, honours the current stage's own `ready_go`, supports a pipeline flush for branch/exception redirect, and counts back-pressure cycles. An optional skid entry registers the upstream ready, cutting the combinational ready chain through the pipeline.

## Interface
- `DATA_W`, 64: payload width in bits; the stage bundle is packed into one vector by the instantiating stage.
- `CNT_W`, 16: width of the stall counter.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  upstream holds a valid bundle.
- `in_ready`  output  1  this register accepts a bundle this cycle.
- `in_data`  input  DATA_W  upstream bundle.
- `ready_go`  input  1  the stage consuming `out_data` has finished its work this cycle.
- `out_ready`  input  1  downstream register accepts.
- `out_valid`  output  1  bundle is complete and offered downstream (`stage_valid & ready_go`).
- `stage_valid`  output  1  the register holds a live bundle, whether finished or not.
- `out_data`  output  DATA_W  held bundle.
- `flush`  input  1  kill every bundle in this register and reject the input this cycle.
- `stall_cnt`  output  CNT_W  saturating count of back-pressured cycles.

## Operation
- Transfer in: `in_valid & in_ready & ~flush`. Transfer out: `out_valid & out_ready`.
- Base mode: `in_ready = ~stage_valid | (ready_go & out_ready)`. This path is combinational.
- Base mode: on an accepted transfer in, `valid_r <= 1` and data loads. If the register drains with no new input, `valid_r <= 0`. Otherwise data holds, including while `in_valid` is low.
- `flush` has priority over everything. On a flush, every valid bit clears on the next edge, the input is discarded, and data registers keep their old value. `in_ready` is not forced low by `flush`.
- The stall counter increments when `stage_valid & ~(ready_go & out_ready)`. It saturates at all-ones and is not cleared by `flush`.
- No data path arithmetic; payload is opaque.

## Timing
- Reset (`rst` low at an edge): `stage_valid=0`, `out_valid=0`, `out_data=0`, `stall_cnt=0`, and the skid entry is empty. `in_ready` is 1 in the first cycle after reset.
- Latency: a bundle accepted at edge N appears on `out_data` at N+1. This holds in both modes.
- Full throughput: one bundle per cycle when `ready_go` and `out_ready` stay high.
- Accept and drain in the same cycle replaces the contents; `stage_valid` stays 1.
- `ready_go` low keeps `out_valid` low while `stage_valid` stays 1.
- Reset asserted mid-transfer wins over handshake and `flush`.

## Configuration
- `PIPE_SKID_EN` defined:
  - Adds a one-entry skid register.
  - `in_ready` becomes a flop: `in_ready = ~skid_valid`.
  - An input accepted while the main entry is held goes to the skid entry.
  - When the main entry drains, skid moves to main on the same edge, and skid empties unless a new input arrives. In that case the new input refills skid only if main is still full after the move; otherwise it goes to main.
  - Order is strictly preserved.
  - `flush` empties both entries.
  - `stage_valid` reflects only the main entry.
- `PIPE_SKID_EN` undefined: base behaviour only; no skid storage is synthesised.

## Structure
- Stage bundle widths and field offsets, the `ALU_OP` width, and the `PIPE_SKID_EN` switch belong in the shared core defines header.
- Each stage packs and unpacks its bundle around this register.
- One sub-module: `pipe_skid_buf` holds the skid entry and its valid bit. It is instantiated only under `PIPE_SKID_EN`.

## Test plan
- **Reset:** hold `rst=0` 2 cycles with `in_valid=1`, `in_data=64'h1234`. Require `stage_valid=0`, `out_data=0`, `stall_cnt=0`. Release reset: `in_ready=1`, and `out_data=64'h1234` one cycle later.
- **Streaming:** drive 8 bundles 1..8 back-to-back with `ready_go=out_ready=1`. Require outputs 1..8 on consecutive cycles, one cycle after input, and `stall_cnt` stays 0.
- **Back-pressure:** load value 5, then set `out_ready=0` for 3 cycles.
  - Require `out_data=5` held and `stall_cnt=3`.
  - Base mode: `in_ready=0`.
  - Skid mode: one extra bundle 6 is accepted, then `in_ready=0`; after release, 5 then 6 are delivered.
- **Flush:** main (and skid) full, `flush=1` with `in_valid=1`, `in_data=9`. Next cycle `stage_valid=0`, `out_valid=0`, and 9 is never output.
- **`ready_go` low:** with `ready_go=0` for 2 cycles, require `stage_valid=1`, `out_valid=0`, `stall_cnt` +2, and the bundle is delivered once `ready_go` rises.
- **Counter saturation:** with `CNT_W=4`, stall 20 cycles. Require `stall_cnt=15` and holding.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register.
// The optional skid entry is selected at build time with PIPE_SKID_EN.
package pipe_stage_reg_pkg;

    localparam int unsigned PIPE_DATA_W_DFLT = 64;
    localparam int unsigned PIPE_CNT_W_DFLT  = 16;

    // Source of the main entry's next contents.
    typedef enum logic [1:0] {
        MAIN_HOLD      = 2'd0,
        MAIN_LOAD_IN   = 2'd1,
        MAIN_LOAD_SKID = 2'd2,
        MAIN_EMPTY     = 2'd3
    } main_sel_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer behind the main pipeline register.
// Instantiated by pipe_stage_reg only when PIPE_SKID_EN is defined.
module pipe_skid_buf
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W_DFLT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Skid entry: flush kills it, a load fills it, a pop into main empties it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with flush and stall counter.
// Define PIPE_SKID_EN to add a skid entry that registers in_ready.
//
// Handshake: a bundle moves upstream->here on an edge where
// in_valid & in_ready & ~flush, and here->downstream on an edge where
// out_valid & out_ready. Neither side may withdraw valid data before it moves.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W_DFLT,
    parameter int CNT_W  = PIPE_CNT_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              ready_go,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              stage_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic      w_drain_ok;
    logic      w_main_free;
    logic      w_in_fire;
    main_sel_e w_main_sel;

    assign w_drain_ok  = ready_go & out_ready;
    assign w_main_free = ~r_valid | w_drain_ok;
    assign w_in_fire   = in_valid & in_ready & ~flush;

`ifdef PIPE_SKID_EN
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_skid_load;
    logic              w_skid_pop;

    // Registered ready breaks the combinational ready chain between stages.
    assign in_ready    = ~w_skid_valid;
    assign w_skid_pop  = w_main_free & w_skid_valid;
    // New input lands in skid whenever main is still occupied after this edge.
    assign w_skid_load = w_in_fire & (~w_main_free | w_skid_valid);

    pipe_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_flush (flush),
        .i_load  (w_skid_load),
        .i_pop   (w_skid_pop),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    // Main entry source: skid first (order), then fresh input, else empty.
    always_comb begin
        w_main_sel = MAIN_HOLD;
        if (w_main_free) begin
            if (w_skid_valid) begin
                w_main_sel = MAIN_LOAD_SKID;
            end else if (w_in_fire) begin
                w_main_sel = MAIN_LOAD_IN;
            end else begin
                w_main_sel = MAIN_EMPTY;
            end
        end
    end
`else
    assign in_ready = w_main_free;

    // Main entry source: fresh input when room is available, else drain.
    always_comb begin
        w_main_sel = MAIN_HOLD;
        if (w_main_free) begin
            if (w_in_fire) begin
                w_main_sel = MAIN_LOAD_IN;
            end else begin
                w_main_sel = MAIN_EMPTY;
            end
        end
    end
`endif

    // Main entry: flush clears valid but leaves the data bits untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else begin
            case (w_main_sel)
                MAIN_LOAD_IN: begin
                    r_valid <= 1'b1;
                    r_data  <= in_data;
                end
`ifdef PIPE_SKID_EN
                MAIN_LOAD_SKID: begin
                    r_valid <= 1'b1;
                    r_data  <= w_skid_data;
                end
`endif
                MAIN_EMPTY: begin
                    r_valid <= 1'b0;
                end
                default: begin
                    r_valid <= r_valid;
                end
            endcase
        end
    end

    // Saturating count of cycles the held bundle could not leave.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (r_valid && !w_drain_ok && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stage_valid = r_valid;
    assign out_valid   = r_valid & ready_go;
    assign out_data    = r_data;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (base build, or PIPE_SKID_EN build).
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_data;
    logic        ready_go;
    logic        out_ready;
    logic        flush;

    logic        in_ready;
    logic        out_valid;
    logic        stage_valid;
    logic [63:0] out_data;
    logic [15:0] stall_cnt;

    logic        in_ready4;
    logic        out_valid4;
    logic        stage_valid4;
    logic [63:0] out_data4;
    logic [3:0]  stall_cnt4;

    int n_vec;
    int n_err;

    pipe_stage_reg #(.DATA_W(64), .CNT_W(16)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .ready_go    (ready_go),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .stage_valid (stage_valid),
        .out_data    (out_data),
        .flush       (flush),
        .stall_cnt   (stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(64), .CNT_W(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready4),
        .in_data     (in_data),
        .ready_go    (ready_go),
        .out_ready   (out_ready),
        .out_valid   (out_valid4),
        .stage_valid (stage_valid4),
        .out_data    (out_data4),
        .flush       (flush),
        .stall_cnt   (stall_cnt4)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are checked at the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 64'h1234;
        ready_go = 1'b1; out_ready = 1'b1; flush = 1'b0;
        cyc(); cyc();
        n_vec++; if (stage_valid !== 1'b0) begin n_err++; $display("FAIL reset_stage_valid: got %0b want 0", stage_valid); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_vec++; if (out_data !== 64'h0) begin n_err++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
        n_vec++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        rst = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        cyc();
        n_vec++; if (out_data !== 64'h1234) begin n_err++; $display("FAIL reset_first_data: got %0h want 1234", out_data); end
        n_vec++; if (stage_valid !== 1'b1) begin n_err++; $display("FAIL reset_first_valid: got %0b want 1", stage_valid); end
        in_valid = 1'b0;
        cyc();
        n_vec++; if (stage_valid !== 1'b0) begin n_err++; $display("FAIL reset_drain: got %0b want 0", stage_valid); end
    endtask

    task automatic test_streaming();
        in_valid = 1'b1; in_data = 64'd1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            n_vec++; if (out_data !== 64'(i) || out_valid !== 1'b1) begin
                n_err++; $display("FAIL stream_%0d: got data %0h valid %0b want %0h valid 1", i, out_data, out_valid, i);
            end
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready_%0d: got %0b want 1", i, in_ready); end
            if (i == 8) in_valid = 1'b0;
            in_data = 64'(i + 1);
        end
        n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL stream_stall_cnt: got %0d want 0", stall_cnt); end
        cyc();
        n_vec++; if (stage_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %0b want 0", stage_valid); end
    endtask

    task automatic test_back_pressure();
        in_valid = 1'b1; in_data = 64'd5;
        cyc();
        n_vec++; if (out_data !== 64'd5) begin n_err++; $display("FAIL bp_load: got %0h want 5", out_data); end
        out_ready = 1'b0; in_data = 64'd6;
        #1;
`ifdef PIPE_SKID_EN
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_skid_ready: got %0b want 1", in_ready); end
`else
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_base_ready: got %0b want 0", in_ready); end
`endif
        cyc();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %0b want 0", in_ready); end
        cyc(); cyc();
        n_vec++; if (out_data !== 64'd5) begin n_err++; $display("FAIL bp_hold: got %0h want 5", out_data); end
        n_vec++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL bp_stall_cnt: got %0d want 3", stall_cnt); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %0b want 1", out_valid); end
        out_ready = 1'b1;
`ifdef PIPE_SKID_EN
        in_valid = 1'b0;
`endif
        cyc();
        n_vec++; if (out_data !== 64'd6 || stage_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_second: got %0h valid %0b want 6 valid 1", out_data, stage_valid);
        end
        in_valid = 1'b0;
        cyc();
        n_vec++; if (stage_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %0b want 0", stage_valid); end
        n_vec++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL bp_stall_after: got %0d want 3", stall_cnt); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = 64'd7;
        cyc();
        out_ready = 1'b0; in_data = 64'd8;
        cyc();
        flush = 1'b1; in_data = 64'd9;
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_vec++; if (stage_valid !== 1'b0) begin n_err++; $display("FAIL flush_stage_valid: got %0b want 0", stage_valid); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %0b want 0", out_valid); end
        n_vec++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL flush_stall_cnt: got %0d want 5", stall_cnt); end
        cyc(); cyc();
        n_vec++; if (stage_valid !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_nothing_out: got stage_valid %0b out_valid %0b data %0h want 0 0", stage_valid, out_valid, out_data);
        end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_ready_go();
        in_valid = 1'b1; in_data = 64'hA;
        cyc();
        in_valid = 1'b0; ready_go = 1'b0;
        cyc(); cyc();
        n_vec++; if (stage_valid !== 1'b1) begin n_err++; $display("FAIL rg_stage_valid: got %0b want 1", stage_valid); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rg_out_valid: got %0b want 0", out_valid); end
        n_vec++; if (stall_cnt !== 16'd7) begin n_err++; $display("FAIL rg_stall_cnt: got %0d want 7", stall_cnt); end
        ready_go = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b1 || out_data !== 64'hA) begin
            n_err++; $display("FAIL rg_deliver: got valid %0b data %0h want 1 a", out_valid, out_data);
        end
        cyc();
        n_vec++; if (stage_valid !== 1'b0) begin n_err++; $display("FAIL rg_drain: got %0b want 0", stage_valid); end
    endtask

    task automatic test_saturation();
        in_valid = 1'b1; in_data = 64'hB;
        cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (20) cyc();
        n_vec++; if (stall_cnt4 !== 4'd15) begin n_err++; $display("FAIL sat_cnt4: got %0d want 15", stall_cnt4); end
        n_vec++; if (stall_cnt !== 16'd27) begin n_err++; $display("FAIL sat_cnt16: got %0d want 27", stall_cnt); end
        n_vec++; if (out_data !== 64'hB) begin n_err++; $display("FAIL sat_hold: got %0h want b", out_data); end
        cyc();
        n_vec++; if (stall_cnt4 !== 4'd15) begin n_err++; $display("FAIL sat_cnt4_hold: got %0d want 15", stall_cnt4); end
        n_vec++; if (stall_cnt !== 16'd28) begin n_err++; $display("FAIL sat_cnt16_next: got %0d want 28", stall_cnt); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 64'hD;
        cyc();
        n_vec++; if (stage_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stage_valid: got %0b want 0", stage_valid); end
        n_vec++; if (out_data !== 64'h0) begin n_err++; $display("FAIL rmid_out_data: got %0h want 0", out_data); end
        n_vec++; if (stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
            n_err++; $display("FAIL rmid_stall_cnt: got %0d/%0d want 0/0", stall_cnt, stall_cnt4);
        end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready: got %0b want 1", in_ready); end
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        n_vec++; if (stage_valid !== 1'b0) begin n_err++; $display("FAIL rmid_after: got %0b want 0", stage_valid); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_ready_go();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
